prev_frame_buffer: RTL and testbench

- Responder side of the previous-frame request interface driven by the frame-difference pipeline.
- Stores each incoming 8-bit grey frame into on-chip banks.
- On each pre_frame_img_req, returns the pixel at the same raster position from the frame that ended FRAME_DLY frames earlier.
- Sits beside the frame-difference top, fed by the same camera/grey stream that feeds its current-frame input.

---
 rtl/prev_frame_buffer.sv | 168 ++++++++++++++++
 tb/tb_prev_frame_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prev_frame_buffer.sv
// ---------------------------------------------------------------------------
// prev_frame_buffer
//   Stores each incoming 8-bit grey frame into one of FRAME_DLY+1 on-chip
//   banks. Each read request returns the pixel at the same raster position
//   from the oldest complete frame, with a fixed latency of one clock.
//
// Ports
//   clk, rst_n              : system clock, asynchronous active-low reset
//   i_cur_img_vsync         : write-side frame envelope (high for whole frame)
//   i_cur_img_hsync         : write-side line envelope (not used)
//   i_cur_img_valid         : write-side pixel strobe
//   i_cur_img_data   [7:0]  : write-side pixel
//   i_pre_frame_img_vsync   : read-side frame envelope (high for whole frame)
//   i_pre_frame_img_hsync   : read-side line envelope (not used)
//   i_pre_frame_img_req     : read-side pixel request
//   o_pre_frame_img_data [7:0] : requested previous-frame pixel
//   o_frame_ready           : FRAME_DLY complete frames are stored
//   o_wr_overflow           : sticky, a write was attempted past the frame end
// ---------------------------------------------------------------------------
module prev_frame_buffer #(
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 480,
   parameter int FRAME_DLY = 1,
   parameter int ADDR_W    = 19
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_cur_img_vsync,
   input  logic       i_cur_img_hsync,
   input  logic       i_cur_img_valid,
   input  logic [7:0] i_cur_img_data,
   input  logic       i_pre_frame_img_vsync,
   input  logic       i_pre_frame_img_hsync,
   input  logic       i_pre_frame_img_req,
   output logic [7:0] o_pre_frame_img_data,
   output logic       o_frame_ready,
   output logic       o_wr_overflow
);

   localparam int NUM_BANK = FRAME_DLY + 1;
   localparam int PIX      = IMG_W * IMG_H;
   localparam int BANK_W   = (NUM_BANK > 2) ? 2 : 1;
   localparam int CNT_W    = (FRAME_DLY > 1) ? 2 : 1;

   // Address counters carry one extra bit so they can sit at PIX (frame end).
   localparam logic [ADDR_W:0]   PIX_CNT   = (ADDR_W + 1)'(PIX);
   localparam logic [ADDR_W:0]   ADDR_ONE  = (ADDR_W + 1)'(1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);
   localparam logic [CNT_W-1:0]  DLY_CNT   = CNT_W'(FRAME_DLY);

   function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
      return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
   endfunction

   logic [7:0]        r_mem [NUM_BANK][PIX];
   logic [7:0]        r_ram_q;
   logic              r_rd_zero;
   logic              r_cur_vsync_d;
   logic              r_pre_vsync_d;
   logic [ADDR_W:0]   r_wr_addr;
   logic [ADDR_W:0]   r_rd_addr;
   logic [BANK_W-1:0] r_wr_bank;
   logic [BANK_W-1:0] r_rd_bank_lat;
   logic              r_rd_ready_lat;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic              r_frame_ready;
   logic              r_wr_overflow;

   logic              w_cur_rise;
   logic              w_cur_fall;
   logic              w_pre_rise;
   logic              w_wr_fire;
   logic              w_wr_en;
   logic [ADDR_W:0]   w_wr_addr;
   logic              w_rd_fire;
   logic              w_rd_en;
   logic              w_rd_ready;
   logic [ADDR_W:0]   w_rd_addr;
   logic [BANK_W-1:0] w_rd_bank_now;
   logic [BANK_W-1:0] w_rd_bank;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_unused_hsync;

   assign w_unused_hsync = i_cur_img_hsync | i_pre_frame_img_hsync;

   assign w_cur_rise = i_cur_img_vsync & ~r_cur_vsync_d;
   assign w_cur_fall = ~i_cur_img_vsync & r_cur_vsync_d;
   assign w_pre_rise = i_pre_frame_img_vsync & ~r_pre_vsync_d;

   // Write side: the rise cycle already addresses pixel 0.
   assign w_wr_addr = w_cur_rise ? '0 : r_wr_addr;
   assign w_wr_fire = i_cur_img_vsync & i_cur_img_valid;
   assign w_wr_en   = w_wr_fire & (w_wr_addr != PIX_CNT);

   // Oldest complete frame is the bank after the one being written. On a read
   // rise the live value is used in the same cycle and latched for the frame,
   // so a later rotation cannot disturb the read in progress.
   assign w_rd_bank_now = next_bank(r_wr_bank);
   assign w_rd_bank     = w_pre_rise ? w_rd_bank_now : r_rd_bank_lat;
   assign w_rd_ready    = w_pre_rise ? r_frame_ready : r_rd_ready_lat;
   assign w_rd_addr     = w_pre_rise ? '0 : r_rd_addr;
   assign w_rd_fire     = i_pre_frame_img_vsync & i_pre_frame_img_req;
   assign w_rd_en       = w_rd_fire & w_rd_ready & (w_rd_addr != PIX_CNT);

   assign w_cnt_next = (r_frame_cnt == DLY_CNT) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);

   // NOTE: the pixel store has no reset; clearing it would prevent block RAM
   // inference, and stale contents are masked by the frame-ready logic.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_bank][w_wr_addr[ADDR_W-1:0]] <= i_cur_img_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd_en) begin
         r_ram_q <= r_mem[w_rd_bank][w_rd_addr[ADDR_W-1:0]];
      end
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_vsync_d  <= 1'b0;
         r_pre_vsync_d  <= 1'b0;
         r_wr_addr      <= '0;
         r_rd_addr      <= '0;
         r_wr_bank      <= '0;
         r_rd_bank_lat  <= '0;
         r_rd_ready_lat <= 1'b0;
         r_frame_cnt    <= '0;
         r_frame_ready  <= 1'b0;
         r_wr_overflow  <= 1'b0;
         r_rd_zero      <= 1'b1;
      end else begin
         r_cur_vsync_d <= i_cur_img_vsync;
         r_pre_vsync_d <= i_pre_frame_img_vsync;

         r_wr_addr <= w_wr_en ? w_wr_addr + ADDR_ONE : w_wr_addr;
         if (w_wr_fire && !w_wr_en) begin
            r_wr_overflow <= 1'b1;
         end

         if (w_cur_fall) begin
            r_wr_bank     <= next_bank(r_wr_bank);
            r_frame_cnt   <= w_cnt_next;
            r_frame_ready <= (w_cnt_next == DLY_CNT);
         end

         if (w_pre_rise) begin
            r_rd_bank_lat  <= w_rd_bank_now;
            r_rd_ready_lat <= r_frame_ready;
         end
         r_rd_addr <= (w_rd_fire && (w_rd_addr != PIX_CNT)) ? w_rd_addr + ADDR_ONE : w_rd_addr;
         // Output forced to zero for not-ready frames and reads past the end;
         // with no request both this flag and the RAM register hold.
         if (w_rd_fire) begin
            r_rd_zero <= ~w_rd_en;
         end
      end
   end

   assign o_pre_frame_img_data = r_rd_zero ? 8'd0 : r_ram_q;
   assign o_frame_ready        = r_frame_ready;
   assign o_wr_overflow        = r_wr_overflow;

endmodule

// File: tb/tb_prev_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_prev_frame_buffer
//   Two 4x2 instances: unit 0 with FRAME_DLY=1, unit 1 with FRAME_DLY=2.
//   A frame-level model (list of completed frame images) predicts the outputs
//   every cycle; directed frames also carry hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_prev_frame_buffer;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int PIX = W * H;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cv[2], ch[2], cval[2], pv[2], ph[2], preq[2];
   logic [7:0] cd[2];
   logic [7:0] odat[2];
   logic       ordy[2], oovf[2];

   int total = 0;
   int bad   = 0;

   prev_frame_buffer #(.IMG_W(W), .IMG_H(H), .FRAME_DLY(1), .ADDR_W(3)) u_dly1 (
      .clk(clk), .rst_n(rst_n),
      .i_cur_img_vsync(cv[0]), .i_cur_img_hsync(ch[0]), .i_cur_img_valid(cval[0]),
      .i_cur_img_data(cd[0]),
      .i_pre_frame_img_vsync(pv[0]), .i_pre_frame_img_hsync(ph[0]),
      .i_pre_frame_img_req(preq[0]),
      .o_pre_frame_img_data(odat[0]), .o_frame_ready(ordy[0]), .o_wr_overflow(oovf[0])
   );

   prev_frame_buffer #(.IMG_W(W), .IMG_H(H), .FRAME_DLY(2), .ADDR_W(3)) u_dly2 (
      .clk(clk), .rst_n(rst_n),
      .i_cur_img_vsync(cv[1]), .i_cur_img_hsync(ch[1]), .i_cur_img_valid(cval[1]),
      .i_cur_img_data(cd[1]),
      .i_pre_frame_img_vsync(pv[1]), .i_pre_frame_img_hsync(ph[1]),
      .i_pre_frame_img_req(preq[1]),
      .o_pre_frame_img_data(odat[1]), .o_frame_ready(ordy[1]), .o_wr_overflow(oovf[1])
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   int dly[2] = '{1, 2};
   int m_img[2][16][PIX];   // image of every completed frame, -1 = unknown
   int m_cur[2][PIX];       // frame being written
   int m_done[2], m_waddr[2], m_raddr[2], m_src[2];
   bit m_rdy_lat[2], m_cvd[2], m_pvd[2];
   int exp_data[2];
   bit exp_ready[2], exp_ovf[2];

   task automatic model_reset(int u);
      m_done[u]    = 0;
      m_waddr[u]   = 0;
      m_raddr[u]   = 0;
      m_src[u]     = 0;
      m_rdy_lat[u] = 1'b0;
      m_cvd[u]     = 1'b0;
      m_pvd[u]     = 1'b0;
      exp_data[u]  = 0;
      exp_ready[u] = 1'b0;
      exp_ovf[u]   = 1'b0;
   endtask

   task automatic model_step(int u);
      bit c_rise, c_fall, p_rise;
      c_rise = cv[u] && !m_cvd[u];
      c_fall = !cv[u] && m_cvd[u];
      p_rise = pv[u] && !m_pvd[u];
      // read frame sources the frame completed dly frames before the newest
      if (p_rise) begin
         m_rdy_lat[u] = (m_done[u] >= dly[u]);
         m_src[u]     = m_done[u] - dly[u];
         m_raddr[u]   = 0;
      end
      if (pv[u] && preq[u]) begin
         if (!m_rdy_lat[u] || m_raddr[u] >= PIX) begin
            exp_data[u] = 0;
         end else begin
            exp_data[u] = m_img[u][m_src[u]][m_raddr[u]];
            m_raddr[u]++;
         end
      end
      // a new frame starts from whatever its storage held dly+1 frames ago
      if (c_rise) begin
         for (int p = 0; p < PIX; p++)
            m_cur[u][p] = (m_done[u] >= dly[u] + 1) ? m_img[u][m_done[u] - dly[u] - 1][p] : -1;
         m_waddr[u] = 0;
      end
      if (cv[u] && cval[u]) begin
         if (m_waddr[u] >= PIX) begin
            exp_ovf[u] = 1'b1;
         end else begin
            m_cur[u][m_waddr[u]] = int'(cd[u]);
            m_waddr[u]++;
         end
      end
      if (c_fall) begin
         for (int p = 0; p < PIX; p++) m_img[u][m_done[u]][p] = m_cur[u][p];
         m_done[u]++;
      end
      exp_ready[u] = (m_done[u] >= dly[u]);
      m_cvd[u] = cv[u];
      m_pvd[u] = pv[u];
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int u = 0; u < 2; u++) begin
         if (!rst_n) model_reset(u);
         else        model_step(u);
      end
   end

   // compare process: outputs checked every cycle, away from the active edge
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (exp_data[u] >= 0)
            check($sformatf("u%0d data", u), 32'(odat[u]), exp_data[u]);
         check($sformatf("u%0d frame_ready", u), 32'(ordy[u]), 32'(exp_ready[u]));
         check($sformatf("u%0d wr_overflow", u), 32'(oovf[u]), 32'(exp_ovf[u]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(int u, bit c_vs, bit c_val, int c_d, bit p_vs, bit p_req);
      cv[u]   = c_vs;
      cval[u] = c_val;
      ch[u]   = c_val;
      cd[u]   = 8'(c_d);
      pv[u]   = p_vs;
      ph[u]   = p_req;
      preq[u] = p_req;
      @(posedge clk);
      #1;
   endtask

   // unit 0: write and read frames start together; lit_mode 1 = all reads
   // zero, 2 = reads return lit_base+1.. (zero beyond the frame end)
   task automatic aligned_frame(int base, int n_wr, int n_cyc, int req_step,
                                int lit_mode, int lit_base);
      int k = 0;
      for (int i = 0; i < n_cyc; i++) begin
         bit rq;
         rq = (i % req_step) == 0;
         drive(0, 1'b1, i < n_wr, base + i + 1, 1'b1, rq);
         if (rq) begin
            check($sformatf("u0 lit read %0d of frame %0d", k, base), 32'(odat[0]),
                  (lit_mode == 1 || k >= PIX) ? 32'd0 : 32'(lit_base + k + 1));
            k++;
         end
      end
   endtask

   task automatic fall_idle(int u);
      drive(u, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      drive(u, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   // unit 1: read frame rises in the same cycle as the write frame falls
   task automatic dly2_frame(int base, bit first, int lit_mode, int lit_base, int rdy_after_fall);
      for (int i = 0; i < PIX; i++)
         drive(1, 1'b1, 1'b1, base + i + 1, first && i < 7, first && i < 7);
      for (int k = 0; k < PIX; k++) begin
         drive(1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
         if (k == 0) check($sformatf("u1 ready after fall of %0d", base), 32'(ordy[1]),
                           32'(rdy_after_fall));
         check($sformatf("u1 lit read %0d after %0d", k, base), 32'(odat[1]),
               (lit_mode == 1) ? 32'd0 : 32'(lit_base + k + 1));
      end
      drive(1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         cv[u] = 0; ch[u] = 0; cval[u] = 0; cd[u] = 0;
         pv[u] = 0; ph[u] = 0; preq[u] = 0;
      end
      #12;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset data", u), 32'(odat[u]), 32'd0);
         check($sformatf("u%0d reset ready", u), 32'(ordy[u]), 32'd0);
         check($sformatf("u%0d reset ovf", u), 32'(oovf[u]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // FRAME_DLY=2: reads of A, B, C are zero, D's read returns A, then B
      dly2_frame(0,  1'b1, 1, 0,  0);
      dly2_frame(10, 1'b0, 1, 0,  1);
      dly2_frame(20, 1'b0, 2, 0,  1);
      dly2_frame(30, 1'b0, 2, 10, 1);

      // FRAME_DLY=1: frame A, reads zero, ready one cycle after the fall
      aligned_frame(0, 8, 8, 1, 1, 0);
      check("u0 ready before A fall", 32'(ordy[0]), 32'd0);
      drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("u0 ready after A fall", 32'(ordy[0]), 32'd1);
      drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      aligned_frame(10, 8, 8, 1, 2, 0);    // B reads A
      fall_idle(0);
      aligned_frame(20, 8, 8, 1, 2, 10);   // C reads B
      fall_idle(0);
      check("u0 ovf before long frame", 32'(oovf[0]), 32'd0);
      aligned_frame(30, 10, 10, 1, 2, 20); // 10 valids, 10 reqs
      fall_idle(0);
      check("u0 ovf after long frame", 32'(oovf[0]), 32'd1);
      aligned_frame(40, 8, 10, 1, 2, 30);  // only first 8 of the long frame
      fall_idle(0);
      aligned_frame(50, 8, 24, 3, 2, 40);  // gapped requests
      fall_idle(0);

      // asynchronous reset in the middle of a frame
      aligned_frame(60, 4, 4, 1, 2, 50);
      #2;
      rst_n   = 1'b0;
      cv[0]   = 0; cval[0] = 0; pv[0] = 0; preq[0] = 0;
      #1;
      check("u0 data in reset", 32'(odat[0]), 32'd0);
      check("u0 ready in reset", 32'(ordy[0]), 32'd0);
      check("u0 ovf in reset", 32'(oovf[0]), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      aligned_frame(60, 8, 8, 1, 1, 0);
      check("u0 ready before first frame after reset", 32'(ordy[0]), 32'd0);
      drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("u0 ready after first frame after reset", 32'(ordy[0]), 32'd1);
      drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      aligned_frame(70, 8, 8, 1, 2, 60);
      fall_idle(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
